// File: rtl/truth_table_scanner_pkg.sv
// Shared types and defaults for the truth table scanner.
// TTS_SETTLE_CYCLE_EN adds a StSettle state ahead of every sample cycle.
package truth_table_scanner_pkg;

    localparam int unsigned NInDefault = 4;

`ifdef TTS_SETTLE_CYCLE_EN
    typedef enum logic [1:0] {StIdle, StSweep, StSettle, StEmit} state_e;
`else
    typedef enum logic [1:0] {StIdle, StSweep, StEmit} state_e;
`endif

endpackage

// File: rtl/tt_scan_emitter.sv
// Walks the captured truth table, skipping zero bits and offering each one bit
// as a minterm index over a valid/ready handshake.
module tt_scan_emitter #(
    parameter int unsigned N_IN = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [2**N_IN-1:0]   tt_i,
    input  logic                 m_ready_i,
    output logic                 m_valid_o,
    output logic [N_IN-1:0]      m_index_o,
    output logic                 done_o
);

    logic [N_IN-1:0] ptr_q, ptr_d;
    logic            advance;

    always_comb begin
        m_valid_o = en_i && tt_i[ptr_q];
        // Zero bits are skipped unconditionally; one bits wait for the consumer.
        advance   = en_i && (!tt_i[ptr_q] || m_ready_i);
        done_o    = advance && (&ptr_q);
        ptr_d     = '0;
        if (advance) begin
            ptr_d = ptr_q + N_IN'(1);
        end else if (en_i) begin
            ptr_d = ptr_q;
        end
    end

    assign m_index_o = ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Drives every input vector to an external function, captures its truth table and
// minterm count, then streams minterm indices. Optional macro: TTS_SETTLE_CYCLE_EN.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int unsigned N_IN = NInDefault
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic [N_IN-1:0]      vec_out_o,
    input  logic                 f_in_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2**N_IN-1:0]   truth_table_o,
    output logic [N_IN:0]        minterm_cnt_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [N_IN-1:0]      m_index_o
);

    localparam int unsigned TtW = 2**N_IN;

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [TtW-1:0]  tt_q, tt_d;
    logic [N_IN:0]   cnt_q, cnt_d;
    logic            emit_en;
    logic            emit_done;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        tt_d    = tt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    tt_d  = '0;
                    cnt_d = '0;
                    vec_d = '0;
`ifdef TTS_SETTLE_CYCLE_EN
                    state_d = StSettle;
`else
                    state_d = StSweep;
`endif
                end
            end
`ifdef TTS_SETTLE_CYCLE_EN
            StSettle: state_d = StSweep;
`endif
            StSweep: begin
                tt_d[vec_q] = f_in_i;
                if (f_in_i) begin
                    cnt_d = cnt_q + (N_IN + 1)'(1);
                end
                if (&vec_q) begin
                    vec_d   = '0;
                    state_d = StEmit;
                end else begin
                    vec_d = vec_q + N_IN'(1);
`ifdef TTS_SETTLE_CYCLE_EN
                    state_d = StSettle;
`else
                    state_d = StSweep;
`endif
                end
            end
            StEmit: begin
                if (emit_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            vec_q   <= '0;
            tt_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            tt_q    <= tt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign emit_en = (state_q == StEmit);

    tt_scan_emitter #(
        .N_IN (N_IN)
    ) u_emitter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (emit_en),
        .tt_i      (tt_q),
        .m_ready_i (m_ready_i),
        .m_valid_o (m_valid_o),
        .m_index_o (m_index_o),
        .done_o    (emit_done)
    );

    assign vec_out_o     = vec_q;
    assign truth_table_o = tt_q;
    assign minterm_cnt_o = cnt_q;
    assign busy_o        = (state_q != StIdle);
    assign done_o        = emit_done;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner: scoreboard of expected minterm indices,
// directed scans, stall, abort and restart sequences.
module tb_truth_table_scanner;

`ifdef TTS_SETTLE_CYCLE_EN
    localparam int SweepLen  = 32;
    localparam int ExpVecE5  = 2;
`else
    localparam int SweepLen  = 16;
    localparam int ExpVecE5  = 5;
`endif
    localparam int ScanLat = SweepLen + 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  vec_out;
    logic        f_in;
    logic        busy;
    logic        done;
    logic [15:0] truth_table;
    logic [4:0]  minterm_cnt;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_index;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          fn_mode = 0;
    int          done_seen = 0;
    int          done_cyc  = 0;
    int          n_acc     = 0;
    logic [3:0]  exp_q[$];
    bit          prev_stall = 1'b0;
    logic [3:0]  prev_idx   = '0;

    truth_table_scanner #(
        .N_IN (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .vec_out_o     (vec_out),
        .f_in_i        (f_in),
        .busy_o        (busy),
        .done_o        (done),
        .truth_table_o (truth_table),
        .minterm_cnt_o (minterm_cnt),
        .m_valid_o     (m_valid),
        .m_ready_i     (m_ready),
        .m_index_o     (m_index)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // External function: ~a~cd | a~c~d | b~cd | ~a~bc~d, or a constant
    function automatic logic ref_fn(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (!a && !c && d) || (a && !c && !d) || (b && !c && d) || (!a && !b && c && !d);
    endfunction

    assign f_in = (fn_mode == 0) ? ref_fn(vec_out) : (fn_mode == 2);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard pops on each accepted index
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", 32'(m_valid), 32'd1);
                check("stall_index_hold", 32'(m_index), 32'(prev_idx));
            end
            if (m_valid === 1'b1) begin
                check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
                if (m_ready === 1'b1 && exp_q.size() != 0) begin
                    check("m_index", 32'(m_index), 32'(exp_q.pop_front()));
                    n_acc++;
                end
            end
            prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1);
            prev_idx   = m_index;
            if (done === 1'b1) begin
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_vec_out"}, 32'(vec_out), 32'd0);
        check({tag, "_truth_table"}, 32'(truth_table), 32'd0);
        check({tag, "_minterm_cnt"}, 32'(minterm_cnt), 32'd0);
        check({tag, "_m_index"}, 32'(m_index), 32'd0);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_scan(input int fmode, input bit alt, input logic [15:0] exp_tt,
                            input int exp_cnt, input bit chk_lat, input string tag);
        int start_c;
        int d0;
        fn_mode = fmode;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (exp_tt[i]) exp_q.push_back(4'(i));
        end
        d0      = done_seen;
        start   = 1'b1;
        start_c = cyc;
        tick();
        start = 1'b0;
        for (int k = 0; k < 200 && done_seen == d0; k++) begin
            tick();
            if (alt) m_ready = ~m_ready;
        end
        check({tag, "_done_seen"}, 32'(done_seen), 32'(d0 + 1));
        if (chk_lat) check({tag, "_done_latency"}, 32'(done_cyc - start_c), 32'(ScanLat));
        check({tag, "_truth_table"}, 32'(truth_table), 32'(exp_tt));
        check({tag, "_minterm_cnt"}, 32'(minterm_cnt), 32'(exp_cnt));
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        m_ready = 1'b1;
        tick();
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_vec_idle"}, 32'(vec_out), 32'd0);
        tick();
        check({tag, "_tt_hold"}, 32'(truth_table), 32'(exp_tt));
        check({tag, "_cnt_hold"}, 32'(minterm_cnt), 32'(exp_cnt));
        exp_q.delete();
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        run_scan(0, 1'b0, 16'h3126, 6, 1'b1, "ref");
        run_scan(1, 1'b0, 16'h0000, 0, 1'b1, "zero");
        run_scan(2, 1'b1, 16'hFFFF, 16, 1'b0, "ones_stall");

        // Abort: start re-pulsed mid-sweep, then reset after the third transfer
        fn_mode = 2;
        m_ready = 1'b1;
        n_acc   = 0;
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("repulse_vec_out", 32'(vec_out), 32'(ExpVecE5));
        check("repulse_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 200 && n_acc < 3; k++) tick();
        check("abort_third_accepted", 32'(n_acc), 32'd3);
        rst     = 1'b1;
        m_ready = 1'b0;
        exp_q.delete();
        tick();
        tick();
        check_all_zero("abort");
        rst     = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 40; k++) tick();
        check("abort_no_more_indices", 32'(n_acc), 32'd3);
        check("abort_stays_idle", 32'(busy), 32'd0);

        run_scan(0, 1'b0, 16'h3126, 6, 1'b1, "restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter N_IN, default 4, giving the number of function inputs (legal range 2..6); TT_W = 2**N_IN.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new scan; sampled only in IDLE.
REQ-005 vec_out  output  N_IN  input vector driven to the external combinational function; MSB = a, LSB = d for N_IN=4.
REQ-006 f_in  input  1  function response to vec_out.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse at scan completion.
REQ-009 truth_table  output  TT_W  bit i = f_in sampled with vec_out = i.
REQ-010 minterm_cnt  output  N_IN+1  number of ones in truth_table.
REQ-011 m_valid  output  1  a minterm index is offered.
REQ-012 m_ready  input  1  consumer accepts the index.
REQ-013 m_index  output  N_IN  offered minterm index.

Function
REQ-014 FSM states SHALL be IDLE, SWEEP, SETTLE (only with the macro), EMIT.
REQ-015 In IDLE with start=1, the block SHALL clear truth_table, minterm_cnt and vec_out to 0 and enter SWEEP next cycle. In states other than IDLE, start SHALL be ignored.
REQ-016 Each SWEEP cycle SHALL do three things:
- write f_in into truth_table[vec_out];
- increment minterm_cnt when f_in=1;
- increment vec_out, or enter EMIT with scan pointer 0 when vec_out = TT_W-1.
REQ-017 vec_out SHALL wrap to 0 on entering EMIT and SHALL hold 0 outside SWEEP/SETTLE.
REQ-018 In EMIT, the pointer SHALL advance one position per cycle past zero bits. On a one bit, m_valid=1 and m_index=pointer. The pointer advances on the m_valid&&m_ready cycle.
REQ-019 While m_valid=1 and m_ready=0, m_index and m_valid SHALL stay stable.
REQ-020 Indices SHALL be emitted in strictly ascending order, each one exactly once.
REQ-021 When the pointer leaves TT_W-1, whether by skip or by transfer, the block SHALL pulse done for one cycle in that same cycle and return to IDLE.
REQ-022 An all-zero table SHALL never assert m_valid. EMIT then lasts TT_W cycles.
REQ-023 minterm_cnt SHALL saturate naturally; TT_W fits in N_IN+1 bits, so it never wraps.
REQ-024 After done, truth_table and minterm_cnt SHALL hold until the next accepted start.

Reset
REQ-025 On rst=1 at a clock edge, the following SHALL all go to 0 on that edge:
- state = IDLE;
- vec_out, truth_table, minterm_cnt, m_index, m_valid, done, busy.
REQ-026 Reset mid-SWEEP or mid-EMIT SHALL abort without emitting further indices; rst SHALL take priority over start.

Configuration
REQ-027 Macro TTS_SETTLE_CYCLE_EN SHALL control a settle cycle:
- defined: every vector gets a SETTLE cycle (vec_out driven, no sample) before its SWEEP sample cycle, so the sweep takes 2*TT_W cycles;
- undefined: no SETTLE state exists and the sweep takes TT_W cycles.
The resulting table SHALL be identical either way.

Structure
REQ-028 Package truth_table_scanner_pkg SHALL hold the FSM state enum and the default N_IN constant.
REQ-029 The EMIT pointer, skip logic and handshake SHALL live in one sub-module, tt_scan_emitter. The sweep SHALL remain in the top module.

Verification
REQ-030 Reset check: hold rst 2 cycles -> all outputs 0, busy=0.
REQ-031 Reference-function scan: f_in modelled as ~a~cd | a~c~d | b~cd | ~a~bc~d, m_ready=1, start pulse ->
- truth_table=16'h3126, minterm_cnt=6;
- m_index sequence 1,2,5,8,12,13;
- done 16+16 cycles after start (no macro).
REQ-032 Constant f_in=0 -> truth_table=0, minterm_cnt=0, m_valid never high, done 32 cycles after start.
REQ-033 Constant f_in=1 with m_ready alternating 0/1 -> indices 0..15 in order, each held stable through stalls, minterm_cnt=16, truth_table=16'hFFFF.
REQ-034 Abort and restart ->
- start re-pulsed during SWEEP: ignored;
- rst asserted after the third index is accepted: outputs 0, IDLE, no further indices;
- new start: full correct scan.
REQ-035 With TTS_SETTLE_CYCLE_EN, repeat the REQ-031 stimulus -> same table and indices, with sweep length 32 cycles.
